// File: rtl/display_pkg.sv
// display_pkg: shared state encodings, segment constants and BCD-to-seven-segment mapping
package display_pkg;
    typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2} scan_state_t;
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} conv_state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0: bcd_to_seg = 7'h40;
            4'd1: bcd_to_seg = 7'h79;
            4'd2: bcd_to_seg = 7'h24;
            4'd3: bcd_to_seg = 7'h30;
            4'd4: bcd_to_seg = 7'h19;
            4'd5: bcd_to_seg = 7'h12;
            4'd6: bcd_to_seg = 7'h02;
            4'd7: bcd_to_seg = 7'h78;
            4'd8: bcd_to_seg = 7'h00;
            4'd9: bcd_to_seg = 7'h10;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/display_scan_controller_bcd_converter.sv
// bcd_converter: sequential 6-bit binary to two-digit BCD, six double-dabble shifts per start
module bcd_converter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    logic [5:0] sh_q, sh_d;
    logic [7:0] bcd_q, bcd_d, adj;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    always_comb begin
        adj = {bcd_q[7:4] >= 4'd5 ? bcd_q[7:4] + 4'd3 : bcd_q[7:4],
               bcd_q[3:0] >= 4'd5 ? bcd_q[3:0] + 4'd3 : bcd_q[3:0]};
        sh_d = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            bcd_d = {adj[6:0], sh_q[5]};
            sh_d = {sh_q[4:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            busy_d = cnt_q != 3'd5;
        end else if (start) begin
            sh_d = bin;
            bcd_d = '0;
            cnt_d = '0;
            busy_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;
        end else begin
            sh_q <= sh_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
        end
    end
    // done marks the cycle of the final shift; results are stable the cycle after
    assign done = busy_q && cnt_q == 3'd5;
    assign busy = busy_q;
    assign tens = bcd_q[7:4];
    assign ones = bcd_q[3:0];
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: loads a signed 0..63 value, converts to BCD and scans three digits.
// Optional SCAN_BLANKING_EN blanks all anodes for the first BLANK_TICKS cycles of each slot.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int SCAN_TICKS  = 500000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] value,
    input  logic       is_negative,
    input  logic       is_dec,
    output logic       busy,
    output logic [1:0] digit,
    output logic [2:0] anode,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int TW = $clog2(SCAN_TICKS);
    if (SCAN_TICKS < 2 || BLANK_TICKS >= SCAN_TICKS) begin : g_bad_params
        $error("display_scan_controller: need SCAN_TICKS >= 2 and BLANK_TICKS < SCAN_TICKS");
    end
    conv_state_t conv_q, conv_d;
    scan_state_t scan_q, scan_d;
    logic [TW-1:0] timer_q, timer_d;
    logic cap_neg_q, cap_neg_d, cap_dec_q, cap_dec_d;
    logic [3:0] disp_tens_q, disp_tens_d, disp_ones_q, disp_ones_d;
    logic disp_neg_q, disp_neg_d, disp_dec_q, disp_dec_d;
    logic [2:0] anode_q, anode_d;
    logic [6:0] seg_q, seg_d, cur_seg;
    logic dp_q, dp_d, blank, wrap, start, conv_done;
    logic [3:0] tens, ones;
    logic conv_busy;
    assign start = conv_q == IDLE && load;
    bcd_converter u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .tens  (tens),
        .ones  (ones)
    );
    always_comb begin
        conv_d = conv_q == IDLE ? (load ? CONV : IDLE) :
                 conv_q == CONV ? (conv_done ? COMMIT : CONV) : IDLE;
        cap_neg_d = start ? is_negative : cap_neg_q;
        cap_dec_d = start ? is_dec : cap_dec_q;
        disp_tens_d = conv_q == COMMIT ? tens : disp_tens_q;
        disp_ones_d = conv_q == COMMIT ? ones : disp_ones_q;
        disp_neg_d = conv_q == COMMIT ? cap_neg_q : disp_neg_q;
        disp_dec_d = conv_q == COMMIT ? cap_dec_q : disp_dec_q;
        wrap = timer_q == TW'(SCAN_TICKS - 1);
        timer_d = wrap ? '0 : timer_q + 1'b1;
        scan_d = !wrap ? scan_q : scan_q == D2 ? D0 : scan_state_t'(scan_q + 2'd1);
`ifdef SCAN_BLANKING_EN
        blank = timer_q < TW'(BLANK_TICKS);
`else
        blank = 1'b0;
`endif
        cur_seg = scan_q == D2 ? (disp_neg_q ? SEG_MINUS : SEG_BLANK) :
                  scan_q == D1 ? (disp_tens_q == 4'd0 ? SEG_BLANK : bcd_to_seg(disp_tens_q)) :
                  bcd_to_seg(disp_ones_q);
        anode_d = blank ? 3'b111 : ~(3'b001 << scan_q);
        seg_d = blank ? SEG_BLANK : cur_seg;
        dp_d = blank || !(scan_q == D1 && disp_dec_q);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            conv_q <= IDLE;
            scan_q <= D0;
            timer_q <= '0;
            cap_neg_q <= 1'b0;
            cap_dec_q <= 1'b0;
            disp_tens_q <= '0;
            disp_ones_q <= '0;
            disp_neg_q <= 1'b0;
            disp_dec_q <= 1'b0;
            anode_q <= 3'b111;
            seg_q <= SEG_BLANK;
            dp_q <= 1'b1;
        end else begin
            conv_q <= conv_d;
            scan_q <= scan_d;
            timer_q <= timer_d;
            cap_neg_q <= cap_neg_d;
            cap_dec_q <= cap_dec_d;
            disp_tens_q <= disp_tens_d;
            disp_ones_q <= disp_ones_d;
            disp_neg_q <= disp_neg_d;
            disp_dec_q <= disp_dec_d;
            anode_q <= anode_d;
            seg_q <= seg_d;
            dp_q <= dp_d;
        end
    end
    assign busy = conv_q != IDLE;
    assign digit = scan_q;
    assign anode = anode_q;
    assign seg = seg_q;
    assign dp = dp_q;
endmodule
